// File: rtl/ode_pkg.sv
// Shared definitions for the Euler step sequencer: state encoding and default widths.
package ode_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/euler_step_sequencer_if.sv
// Control/handshake bundle between the start logic, the sequencer and the evaluate/update units.
interface euler_step_sequencer_if
  import ode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              start;
  logic [CNT_W-1:0]  num_steps;
  logic [DATA_W-1:0] h;
  logic [DATA_W-1:0] t0;
  logic              eval_req;
  logic              eval_ack;
  logic              upd_req;
  logic              upd_ack;
  logic [DATA_W-1:0] t_out;
  logic [CNT_W-1:0]  step_cnt;
  logic              busy;
  logic              final_done;

  modport master (
    output start, num_steps, h, t0, eval_ack, upd_ack,
    input  eval_req, upd_req, t_out, step_cnt, busy, final_done
  );

  modport slave (
    input  start, num_steps, h, t0, eval_ack, upd_ack,
    output eval_req, upd_req, t_out, step_cnt, busy, final_done
  );
endinterface

// File: rtl/euler_time_acc.sv
// Simulation-time accumulator: loads t0 at run start, adds the step size after each update.
module euler_time_acc
  import ode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              rst_sync,
  input  logic              load,
  input  logic              add,
  input  logic [DATA_W-1:0] t0,
  input  logic [DATA_W-1:0] h,
  output logic [DATA_W-1:0] t
);

  // Addition wraps modulo 2^DATA_W by construction.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      t <= '0;
    end else if (rst_sync) begin
      t <= '0;
    end else if (load) begin
      t <= t0;
    end else if (add) begin
      t <= t + h;
    end
  end

endmodule

// File: rtl/euler_step_sequencer.sv
// Sequences N forward-Euler iterations as EVAL/UPDATE handshake pairs and tracks simulation time.
module euler_step_sequencer
  import ode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst_async,
  input logic                  rst_sync,
  euler_step_sequencer_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  n_q;
  logic [DATA_W-1:0] h_q;
  logic [DATA_W-1:0] t_q;
  logic              load;
  logic              add;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= ST_IDLE;
    end else if (rst_sync) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the UPDATE handshake advances the count, so cnt_q never passes n_q.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    add     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (bus.num_steps != '0) ? ST_EVAL : ST_DONE;
        end
      end
      ST_EVAL: begin
        if (bus.eval_ack) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (bus.upd_ack) begin
          add     = 1'b1;
          state_d = (cnt_inc == n_q) ? ST_DONE : ST_EVAL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      cnt_q <= '0;
      n_q   <= '0;
      h_q   <= '0;
    end else if (rst_sync) begin
      cnt_q <= '0;
      n_q   <= '0;
      h_q   <= '0;
    end else if (load) begin
      cnt_q <= '0;
      n_q   <= bus.num_steps;
      h_q   <= bus.h;
    end else if (add) begin
      cnt_q <= cnt_inc;
    end
  end

  euler_time_acc #(
    .DATA_W (DATA_W)
  ) u_time_acc (
    .clk       (clk),
    .rst_async (rst_async),
    .rst_sync  (rst_sync),
    .load      (load),
    .add       (add),
    .t0        (bus.t0),
    .h         (h_q),
    .t         (t_q)
  );

  assign bus.eval_req   = (state_q == ST_EVAL);
  assign bus.upd_req    = (state_q == ST_UPDATE);
  assign bus.final_done = (state_q == ST_DONE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.t_out      = t_q;
  assign bus.step_cnt   = cnt_q;

endmodule

// File: tb/tb_euler_step_sequencer.sv
// Scoreboard bench: each run pushes its expected end-of-run snapshot; a monitor checks it at final_done.
module tb_euler_step_sequencer;

  typedef struct {
    logic [31:0] t;
    logic [15:0] cnt;
    int          lat;
    int          ev;
    int          up;
  } exp_t;

  logic clk;
  logic rst_async;
  logic rst_sync;
  int   ack_mode;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  euler_step_sequencer_if #(.DATA_W(32), .CNT_W(16)) bus ();

  euler_step_sequencer #(
    .DATA_W (32),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst_async (rst_async),
    .rst_sync  (rst_sync),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Ack responder: mode 0 ties both acks high; mode 1 holds eval_req for 5 cycles per EVAL.
  initial begin
    int ecnt;
    ecnt = 0;
    bus.eval_ack = 1'b0;
    bus.upd_ack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_mode == 0) begin
        bus.eval_ack = 1'b1;
        bus.upd_ack  = 1'b1;
        ecnt = 0;
      end else begin
        bus.upd_ack = 1'b1;
        if (bus.eval_req) ecnt++;
        else ecnt = 0;
        bus.eval_ack = (ecnt >= 5);
      end
    end
  end

  // Monitor: tracks each accepted run and checks it against the scoreboard at final_done.
  initial begin
    bit   armed;
    int   rc, bc, ec, uc;
    exp_t e;
    armed = 0;
    rc = 0; bc = 0; ec = 0; uc = 0;
    forever begin
      @(negedge clk);
      if (rst_async || rst_sync) begin
        armed = 0;
      end else begin
        if (armed) begin
          rc++;
          if (bus.busy) bc++;
          if (bus.eval_req) ec++;
          if (bus.upd_req) uc++;
          if (bus.final_done) begin
            armed = 0;
            if (exp_q.size() == 0) begin
              chk("unexpected_final_done", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("t_out", 64'(bus.t_out), 64'(e.t));
              chk("step_cnt", 64'(bus.step_cnt), 64'(e.cnt));
              chk("done_latency", 64'(rc), 64'(e.lat));
              chk("busy_cycles", 64'(bc), 64'(e.lat));
              chk("eval_req_cycles", 64'(ec), 64'(e.ev));
              chk("upd_req_cycles", 64'(uc), 64'(e.up));
            end
          end
        end else if (bus.final_done) begin
          chk("final_done_without_run", 64'd1, 64'd0);
        end
        if (!armed && bus.start && !bus.busy) begin
          armed = 1;
          rc = 0; bc = 0; ec = 0; uc = 0;
        end
      end
    end
  end

  task automatic run(input int n, input logic [31:0] hh, input logic [31:0] tt, input bit push,
                     input logic [31:0] et, input int ecnt, input int lat, input int ev, input int up);
    exp_t e;
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.num_steps = 16'(n);
    bus.h         = hh;
    bus.t0        = tt;
    if (push) begin
      e.t = et; e.cnt = 16'(ecnt); e.lat = lat; e.ev = ev; e.up = up;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL run_timeout: %0d runs still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_eval_req"}, 64'(bus.eval_req), 64'd0);
    chk({tag, "_upd_req"}, 64'(bus.upd_req), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_final_done"}, 64'(bus.final_done), 64'd0);
    chk({tag, "_t_out"}, 64'(bus.t_out), 64'd0);
    chk({tag, "_step_cnt"}, 64'(bus.step_cnt), 64'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    ack_mode = 0;
    rst_async = 1'b1;
    rst_sync  = 1'b0;
    bus.start = 1'b0;
    bus.num_steps = '0;
    bus.h  = '0;
    bus.t0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_async = 1'b0;

    // 3 steps, acks tied high: t = 0x100 + 3*0x10, done in cycle 7
    run(3, 32'h10, 32'h100, 1, 32'h130, 3, 7, 3, 3);
    drain(50);

    // zero steps: straight to DONE, busy for a single cycle
    run(0, 32'h7, 32'h55, 1, 32'h55, 0, 1, 0, 0);
    drain(50);

    // eval_ack delayed: 2 x (5 EVAL + 1 UPDATE) + DONE = 13
    ack_mode = 1;
    run(2, 32'h20, 32'h1000, 1, 32'h1040, 2, 13, 10, 2);
    drain(100);
    ack_mode = 0;

    // time wraps to zero
    run(1, 32'h10, 32'hFFFF_FFF0, 1, 32'h0, 1, 3, 1, 1);
    drain(50);

    // start re-pulsed mid-run with other parameters is ignored
    run(4, 32'h3, 32'h0, 1, 32'hC, 4, 9, 4, 4);
    @(posedge clk);
    #1;
    bus.start = 1'b1; bus.num_steps = 16'd9; bus.h = 32'h100; bus.t0 = 32'hAAAA;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain(50);

    // async reset during UPDATE of step 2 (cycle 4)
    run(4, 32'h1, 32'h200, 0, 32'h0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_abort_upd_req", 64'(bus.upd_req), 64'd1);
    chk("pre_abort_step_cnt", 64'(bus.step_cnt), 64'd1);
    rst_async = 1'b1;
    #1;
    chk_zero("async_abort");
    @(posedge clk);
    #1;
    rst_async = 1'b0;
    repeat (12) @(posedge clk);
    run(2, 32'h8, 32'h40, 1, 32'h50, 2, 5, 2, 2);
    drain(50);

    // sync reset mid-run, with start asserted in the same cycle
    run(3, 32'h4, 32'h10, 0, 32'h0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_sync = 1'b1;
    bus.start = 1'b1; bus.num_steps = 16'd5;
    @(posedge clk);
    #1;
    chk_zero("sync_abort");
    rst_sync = 1'b0;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    run(1, 32'h5, 32'h0, 1, 32'h5, 1, 3, 1, 1);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/euler_step_sequencer.md
EULER_STEP_SEQUENCER -- requirements
Module: euler_step_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, width of step size h and time accumulator t (unsigned fixed point, binary point irrelevant to block).
REQ-002 Parameter CNT_W, default 16, width of step count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_async  input  1  asynchronous, active-high reset.
REQ-005 rst_sync  input  1  synchronous, active-high reset; same effect as rst_async, applied at clock edge.
REQ-006 start  input  1  one-cycle start pulse from the start FSM.
REQ-007 num_steps  input  CNT_W  number of Euler iterations; sampled with start.
REQ-008 h  input  DATA_W  step size; sampled with start.
REQ-009 t0  input  DATA_W  initial time; sampled with start.
REQ-010 eval_req  output  1  request derivative evaluation f(x,t).
REQ-011 eval_ack  input  1  derivative unit done.
REQ-012 upd_req  output  1  request state update x <= x + h*f.
REQ-013 upd_ack  input  1  update unit done.
REQ-014 t_out  output  DATA_W  current simulation time.
REQ-015 step_cnt  output  CNT_W  completed iterations.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 final_done  output  1  one-cycle pulse at end of run.

Function
REQ-018 States: IDLE, EVAL, UPDATE, DONE; eval_req, upd_req, busy, final_done decoded as Moore outputs from state only.
REQ-019 eval_req = 1 exactly in EVAL; upd_req = 1 exactly in UPDATE; final_done = 1 exactly in DONE.
REQ-020 IDLE: start=1 latches num_steps, h into internal registers, loads t_out <= t0, step_cnt <= 0; next state EVAL if num_steps != 0, else DONE.
REQ-021 IDLE: start=0 holds state; t_out and step_cnt hold last values.
REQ-022 EVAL: eval_ack=1 at edge -> UPDATE; else remain EVAL (req held indefinitely, no timeout).
REQ-023 UPDATE: upd_ack=1 at edge -> step_cnt += 1, t_out += latched h (modulo 2^DATA_W, wrap silently); next state DONE if step_cnt+1 == latched num_steps, else EVAL.
REQ-024 DONE: unconditional -> IDLE after one cycle.
REQ-025 start while busy=1 ignored; latched parameters unchanged.
REQ-026 eval_ack outside EVAL and upd_ack outside UPDATE ignored.
REQ-027 eval_ack and upd_ack both high in EVAL: only eval_ack acts; upd_ack ignored.
REQ-028 Minimum latency per iteration 2 cycles (ack tied high); run with N steps and acks tied high: final_done in cycle 2N+1 after start edge.
REQ-029 num_steps = 2^CNT_W-1 completes without counter overflow; step_cnt never exceeds latched num_steps.

Reset
REQ-030 rst_async or rst_sync: state IDLE, step_cnt 0, t_out 0, latched h and num_steps 0; eval_req, upd_req, busy, final_done 0.
REQ-031 Reset mid-run aborts immediately; no final_done pulse issued for aborted run.
REQ-032 Reset has priority over start and acks in the same cycle.

Structure
REQ-033 Shared package ode_pkg holds state enumeration and DATA_W/CNT_W default constants.
REQ-034 One sub-module euler_time_acc: DATA_W register with load(t0) and add(h) controls, wrap-around add.

Verification
REQ-035 num_steps=3, h=0x10, t0=0x100, acks tied 1 -> 3 eval/upd pairs, t_out=0x130, step_cnt=3, final_done one cycle at cycle 7.
REQ-036 num_steps=0, start pulse -> no eval_req/upd_req, final_done at cycle 1, busy high one cycle.
REQ-037 num_steps=2, eval_ack delayed 5 cycles each -> eval_req held 5 cycles each, run ends step_cnt=2.
REQ-038 t0=0xFFFFFFF0, h=0x10, num_steps=1 -> t_out=0x00000000 after update.
REQ-039 start re-pulsed during run with num_steps=9 -> ignored; original num_steps=4 run completes with step_cnt=4.
REQ-040 rst_async asserted in UPDATE of step 2 -> all outputs 0 same cycle, no final_done; subsequent start runs normally.
